memory_display_scanner: RTL

MEMORY_DISPLAY_SCANNER -- requirements
Module: memory_display_scanner

---
 rtl/memory_display_scanner.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/memory_display_scanner.sv
// Four-digit seven-segment scanner showing two register-file entries (page) with their addresses.
// Optional auto page scrolling is enabled by defining MEMORY_DISPLAY_AUTO_SCROLL_EN.
module memory_display_scanner #(
  parameter int REFRESH_DIV     = 100000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_FRAMES     = 256
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] mem_flat,
  input  logic        page_btn,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  page
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       digit;
  logic [31:0]      snap_mem;
  logic [1:0]       snap_page;
  logic             tick;
  logic             frame_start;

  logic             sync1, sync2;
  logic             deb_level;
  logic [DB_W-1:0]  db_cnt;
  logic             press;
  logic             page_step;

  assign tick        = (div_cnt == DIV_LAST);
  assign frame_start = tick && (digit == 2'd3);

  // The digit-0 slot must already see the snapshot being latched on this same tick.
  logic [31:0] view_mem;
  logic [1:0]  view_page;
  logic [2:0]  addr_lo, addr_hi;
  logic [3:0]  nib_lo, nib_hi;
  logic [1:0]  digit_next;
  logic [3:0]  disp_nib;
  logic        disp_dp;
  logic [3:0]  an_next;

  always_comb begin
    view_mem   = frame_start ? mem_flat : snap_mem;
    view_page  = frame_start ? page : snap_page;
    addr_lo    = {view_page, 1'b0};
    addr_hi    = {view_page, 1'b1};
    nib_lo     = view_mem[{addr_lo, 2'b00} +: 4];
    nib_hi     = view_mem[{addr_hi, 2'b00} +: 4];
    digit_next = digit + 2'd1;
    disp_nib   = 4'h0;
    disp_dp    = 1'b1;
    case (digit_next)
      2'd0: begin disp_nib = nib_hi;           disp_dp = 1'b1; end
      2'd1: begin disp_nib = {1'b0, addr_hi};  disp_dp = 1'b0; end
      2'd2: begin disp_nib = nib_lo;           disp_dp = 1'b1; end
      default: begin disp_nib = {1'b0, addr_lo}; disp_dp = 1'b0; end
    endcase
    an_next = ~(4'b0001 << digit_next);
  end

  // Scan divider, digit index, frame snapshot and registered display drive.
  always_ff @(posedge CLK) begin
    if (reset) begin
      div_cnt   <= '0;
      digit     <= 2'd3;
      snap_mem  <= '0;
      snap_page <= '0;
      an        <= 4'b1111;
      seg       <= 7'b1111111;
      dp        <= 1'b1;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        digit <= digit_next;
        an    <= an_next;
        seg   <= hex_to_seg(disp_nib);
        dp    <= disp_dp;
        if (frame_start) begin
          snap_mem  <= mem_flat;
          snap_page <= page;
        end
      end
    end
  end

  // Button synchronizer and debounce: a level is accepted only after a full run of disagreement.
  always_ff @(posedge CLK) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      deb_level <= 1'b0;
      db_cnt    <= '0;
    end else begin
      sync1 <= page_btn;
      sync2 <= sync1;
      if (sync2 != deb_level) begin
        if (db_cnt == DB_LAST) begin
          deb_level <= sync2;
          db_cnt    <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign press = (sync2 != deb_level) && (db_cnt == DB_LAST) && sync2;

`ifdef MEMORY_DISPLAY_AUTO_SCROLL_EN
  localparam int FC_W = $clog2(AUTO_FRAMES + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(AUTO_FRAMES - 1);

  logic [FC_W-1:0] frame_cnt;
  logic            auto_adv;

  assign auto_adv = frame_start && (frame_cnt == FC_LAST);

  // A manual press restarts the auto-scroll interval.
  always_ff @(posedge CLK) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (press) begin
      frame_cnt <= '0;
    end else if (frame_start) begin
      frame_cnt <= auto_adv ? '0 : frame_cnt + 1'b1;
    end
  end

  assign page_step = press || auto_adv;
`else
  assign page_step = press;
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      page <= 2'd0;
    end else if (page_step) begin
      page <= page + 2'd1;
    end
  end

endmodule
